// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// timed-stall FSM states and default widths.
package pipe_ctrl_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int DEF_PC_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        TIMED = 1'b1
    } timed_state_t;

    // Mask with the low 'count' bits set; callers slice it to the stage count.
    function automatic logic [31:0] low_ones(input int unsigned count);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = (i < count);
        end
        return r;
    endfunction

endpackage

// File: rtl/stall_mask_gen.sv
// Prefix stall mask: every bit from 0 up to the highest set request bit is
// set, built as a per-bit suffix-OR so no combinational chain is formed.
module stall_mask_gen #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] eff,
    output logic [WIDTH-1:0] mask
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign mask[i] = |eff[WIDTH-1:i];
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: prefix stall merge, counted stall for iterative units,
// registered branch/exception flush-and-redirect, and a stall watchdog.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  IDLE  | no counted stall; a timed_req with nonzero length is accepted
//  TIMED | counted stall active, cnt_q cycles remain including this one
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_STAGES    = 6,
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int TIMED_STAGE = STG_EX,
    parameter int BR_STAGE    = STG_EX,
    parameter int EXC_STAGE   = STG_MEM,
    parameter int WDOG_WIDTH  = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_STAGES-1:0]  stallreq,
    input  logic                 timed_req,
    input  logic [CNT_WIDTH-1:0] timed_len,
    input  logic                 br_req,
    input  logic [PC_WIDTH-1:0]  br_pc,
    input  logic                 exc_req,
    input  logic [PC_WIDTH-1:0]  exc_pc,
    output logic [N_STAGES-1:0]  stall,
    output logic [N_STAGES-1:0]  flush,
    output logic                 redirect_valid,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 timed_busy,
    output logic                 wdog_err
);

    localparam logic [31:0]           EXC_FLUSH_W = low_ones(EXC_STAGE + 1);
    localparam logic [31:0]           BR_FLUSH_W  = low_ones(BR_STAGE);
    localparam logic [N_STAGES-1:0]   EXC_FLUSH   = EXC_FLUSH_W[N_STAGES-1:0];
    localparam logic [N_STAGES-1:0]   BR_FLUSH    = BR_FLUSH_W[N_STAGES-1:0];
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [WDOG_WIDTH-1:0] WDOG_MAX    = '1;
    localparam logic [WDOG_WIDTH-1:0] WDOG_ONE    = WDOG_WIDTH'(1);

    timed_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [N_STAGES-1:0]   eff;
    logic [N_STAGES-1:0]   mask;
    logic                  br_accept;
    logic [WDOG_WIDTH-1:0] wdog_cnt;

    assign timed_busy = (state_q == TIMED);

    always_comb begin
        eff              = stallreq;
        eff[TIMED_STAGE] = stallreq[TIMED_STAGE] | timed_busy;
    end

    stall_mask_gen #(
        .WIDTH (N_STAGES)
    ) u_stall_mask_gen (
        .eff  (eff),
        .mask (mask)
    );

    // A stage being flushed this cycle takes a bubble instead of freezing.
    assign stall = RST ? '0 : (mask & ~flush);

    assign br_accept = br_req & ~exc_req & ~stall[BR_STAGE];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_req) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (timed_req && (timed_len != '0)) begin
                        state_d = TIMED;
                        cnt_d   = timed_len;
                    end
                end
                TIMED: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            flush          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (exc_req) begin
            flush          <= EXC_FLUSH;
            redirect_valid <= 1'b1;
            redirect_pc    <= exc_pc;
        end else if (br_accept) begin
            flush          <= BR_FLUSH;
            redirect_valid <= 1'b1;
            redirect_pc    <= br_pc;
        end else begin
            flush          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end
    end

    // Error is raised on the edge after the counter sits at its saturated value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (stall[0]) begin
                if (wdog_cnt != WDOG_MAX) begin
                    wdog_cnt <= wdog_cnt + WDOG_ONE;
                end
            end else begin
                wdog_cnt <= '0;
            end
            if (wdog_cnt == WDOG_MAX) begin
                wdog_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: prefix stall, timed stall, branch and
// exception redirects, back-to-back pulses, watchdog and mid-operation reset.
module tb_pipe_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [5:0]  stallreq;
    logic        timed_req;
    logic [5:0]  timed_len;
    logic        br_req;
    logic [31:0] br_pc;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        timed_busy;
    logic        wdog_err;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(
        .N_STAGES    (6),
        .PC_WIDTH    (32),
        .CNT_WIDTH   (6),
        .TIMED_STAGE (3),
        .BR_STAGE    (3),
        .EXC_STAGE   (4),
        .WDOG_WIDTH  (4)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .stallreq       (stallreq),
        .timed_req      (timed_req),
        .timed_len      (timed_len),
        .br_req         (br_req),
        .br_pc          (br_pc),
        .exc_req        (exc_req),
        .exc_pc         (exc_pc),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .timed_busy     (timed_busy),
        .wdog_err       (wdog_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; stallreq = 6'b111111; timed_req = 0; timed_len = 0;
        br_req = 0; br_pc = 0; exc_req = 0; exc_pc = 0;
        step(); step();
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall: got %b exp 000000", stall); end
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL reset_flush: got %b exp 000000", flush); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b exp 0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", redirect_pc); end
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", timed_busy); end
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog: got %b exp 0", wdog_err); end
        RST = 1'b0; stallreq = 6'b0;
        step();
    endtask

    task automatic test_prefix();
        logic [5:0] vin [6];
        logic [5:0] vexp [6];
        vin[0] = 6'b000100; vexp[0] = 6'b000111;
        vin[1] = 6'b010010; vexp[1] = 6'b011111;
        vin[2] = 6'b000000; vexp[2] = 6'b000000;
        vin[3] = 6'b100000; vexp[3] = 6'b111111;
        vin[4] = 6'b000001; vexp[4] = 6'b000001;
        vin[5] = 6'b001010; vexp[5] = 6'b001111;
        for (int i = 0; i < 6; i++) begin
            stallreq = vin[i];
            #1;
            checks++;
            if (stall !== vexp[i]) begin
                errors++; $display("FAIL prefix_%0d: in %b got %b exp %b", i, vin[i], stall, vexp[i]);
            end
        end
        stallreq = 6'b0;
        step();
    endtask

    task automatic test_timed();
        timed_req = 1; timed_len = 6'd3;
        step();
        timed_req = 0;
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL timed_c1_busy: got %b exp 1", timed_busy); end
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL timed_c1_stall: got %b exp 001111", stall); end
        step();
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL timed_c2_busy: got %b exp 1", timed_busy); end
        // requests while TIMED and on the returning edge are both dropped
        timed_req = 1; timed_len = 6'd5;
        step();
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL timed_c3_busy: got %b exp 1", timed_busy); end
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL timed_c3_stall: got %b exp 001111", stall); end
        step();
        timed_req = 0;
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL timed_end_busy: got %b exp 0", timed_busy); end
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL timed_end_stall: got %b exp 000000", stall); end
        timed_req = 1; timed_len = 6'd0;
        step();
        timed_req = 0;
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL timed_len0: got %b exp 0", timed_busy); end
        step();
    endtask

    task automatic test_branch();
        br_req = 1; br_pc = 32'h80;
        step();
        br_req = 0;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL br_rv: got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL br_pc: got %h exp 80", redirect_pc); end
        checks++; if (flush !== 6'b000111) begin errors++; $display("FAIL br_flush: got %b exp 000111", flush); end
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL br_rv_clear: got %b exp 0", redirect_valid); end
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL br_flush_clear: got %b exp 000000", flush); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL br_pc_clear: got %h exp 0", redirect_pc); end
        stallreq = 6'b010000; br_req = 1; br_pc = 32'h80;
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL br_blocked_rv: got %b exp 0", redirect_valid); end
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL br_blocked_flush: got %b exp 000000", flush); end
        stallreq = 6'b0;
        step();
        br_req = 0;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL br_held_rv: got %b exp 1", redirect_valid); end
        step();
        // a stall below the branch stage does not block it; flushed stages drop their stall
        stallreq = 6'b000100; br_req = 1; br_pc = 32'h44;
        step();
        br_req = 0;
        checks++; if (redirect_pc !== 32'h44) begin errors++; $display("FAIL br_low_pc: got %h exp 44", redirect_pc); end
        checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL br_flush_override: got %b exp 000000", stall); end
        stallreq = 6'b0;
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL br_low_clear: got %b exp 0", redirect_valid); end
    endtask

    task automatic test_exc_priority();
        timed_req = 1; timed_len = 6'd10;
        step();
        timed_req = 0;
        step();
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL exc_pre_busy: got %b exp 1", timed_busy); end
        exc_req = 1; exc_pc = 32'h100; br_req = 1; br_pc = 32'h80;
        step();
        exc_req = 0; br_req = 0;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL exc_rv: got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL exc_pc: got %h exp 100", redirect_pc); end
        checks++; if (flush !== 6'b011111) begin errors++; $display("FAIL exc_flush: got %b exp 011111", flush); end
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL exc_busy: got %b exp 0", timed_busy); end
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL exc_rv_clear: got %b exp 0", redirect_valid); end
        exc_req = 1; exc_pc = 32'h200; timed_req = 1; timed_len = 6'd3;
        step();
        exc_req = 0; timed_req = 0;
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL exc_drop_timed: got %b exp 0", timed_busy); end
        step();
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL exc_drop_timed2: got %b exp 0", timed_busy); end
    endtask

    task automatic test_back_to_back();
        br_req = 1; br_pc = 32'h10;
        step();
        br_req = 0; exc_req = 1; exc_pc = 32'h20;
        checks++; if (redirect_pc !== 32'h10) begin errors++; $display("FAIL b2b_1_pc: got %h exp 10", redirect_pc); end
        checks++; if (flush !== 6'b000111) begin errors++; $display("FAIL b2b_1_flush: got %b exp 000111", flush); end
        step();
        exc_req = 0; br_req = 1; br_pc = 32'h30;
        checks++; if (redirect_pc !== 32'h20) begin errors++; $display("FAIL b2b_2_pc: got %h exp 20", redirect_pc); end
        checks++; if (flush !== 6'b011111) begin errors++; $display("FAIL b2b_2_flush: got %b exp 011111", flush); end
        step();
        br_req = 0;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL b2b_3_rv: got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h30) begin errors++; $display("FAIL b2b_3_pc: got %h exp 30", redirect_pc); end
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_rv: got %b exp 0", redirect_valid); end
    endtask

    task automatic test_watchdog();
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_pre: got %b exp 0", wdog_err); end
        stallreq = 6'b000010;
        for (int i = 0; i < 14; i++) step();
        stallreq = 6'b0;
        step(); step();
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_14: got %b exp 0", wdog_err); end
        stallreq = 6'b000010;
        for (int i = 0; i < 15; i++) step();
        stallreq = 6'b0;
        step();
        checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_15: got %b exp 1", wdog_err); end
        step(); step();
        checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b exp 1", wdog_err); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_rst: got %b exp 0", wdog_err); end
        step();
    endtask

    task automatic test_midop_reset();
        timed_req = 1; timed_len = 6'd8;
        step();
        timed_req = 0;
        step(); step(); step();
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %b exp 1", timed_busy); end
        RST = 1'b1; exc_req = 1; exc_pc = 32'h300;
        step();
        RST = 1'b0; exc_req = 0;
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b exp 0", timed_busy); end
        checks++; if (flush !== 6'b0) begin errors++; $display("FAIL mid_flush: got %b exp 000000", flush); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mid_rv: got %b exp 0", redirect_valid); end
        timed_req = 1; timed_len = 6'd2;
        step();
        timed_req = 0;
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL mid_restart_busy: got %b exp 1", timed_busy); end
        step();
        checks++; if (timed_busy !== 1'b1) begin errors++; $display("FAIL mid_restart_busy2: got %b exp 1", timed_busy); end
        step();
        checks++; if (timed_busy !== 1'b0) begin errors++; $display("FAIL mid_restart_end: got %b exp 0", timed_busy); end
    endtask

    initial begin
        test_reset();
        test_prefix();
        test_timed();
        test_branch();
        test_exc_priority();
        test_back_to_back();
        test_watchdog();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the RISC-V core.
- Merges per-stage stall requests into a prefix stall vector: a request at stage i freezes stages 0..i.
- Adds a counted multi-cycle stall for iterative units, registered branch/exception flush-and-redirect pulses, and a stall watchdog.
- Sits beside the pipeline registers; drives their stall/flush inputs and the PC redirect.

Parameters:
- N_STAGES, 6, number of pipeline stages; index 0 = PC/IF, N_STAGES-1 = WB.
- PC_WIDTH, 32, redirect PC width.
- CNT_WIDTH, 6, width of timed-stall length.
- TIMED_STAGE, 3, stage owning the timed stall (EX).
- BR_STAGE, 3, stage resolving branches (EX).
- EXC_STAGE, 4, stage committing exceptions (MEM).
- WDOG_WIDTH, 10, watchdog counter width; limit = 2^WDOG_WIDTH-1.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- stallreq  in  N_STAGES  bit i = stage i requests a stall this cycle.
- timed_req  in  1  one-cycle request to start a counted stall.
- timed_len  in  CNT_WIDTH  stall length in cycles; 0 = no stall.
- br_req  in  1  branch mispredict from BR_STAGE.
- br_pc  in  PC_WIDTH  branch target.
- exc_req  in  1  exception/trap from EXC_STAGE.
- exc_pc  in  PC_WIDTH  trap vector.
- stall  out  N_STAGES  freeze per stage (combinational).
- flush  out  N_STAGES  bubble-insert per stage (registered).
- redirect_valid  out  1  PC redirect pulse (registered).
- redirect_pc  out  PC_WIDTH  redirect target (registered).
- timed_busy  out  1  counted stall in progress.
- wdog_err  out  1  sticky watchdog error.

Behaviour:
- Reset (RST=1 at a CLK edge): flush=0, redirect_valid=0, redirect_pc=0, timed count=0, FSM=IDLE, wdog count=0, wdog_err=0. stall=0 combinationally while RST=1.
- Effective request: eff = stallreq | (timed_busy << TIMED_STAGE).
- stall: k = highest set bit of eff; stall[k:0]=1 and all higher bits 0. eff=0 gives stall=0. Example for N=6: request at bit 4 gives 011111; at bit 2 gives 000111.
- flush override: in any cycle where flush[i]=1, stall[i] is forced to 0.
- Timed FSM, states IDLE and TIMED:
  - IDLE: timed_req=1 with timed_len=L>0 loads cnt=L and moves to TIMED. timed_busy is 1 for cycles t+1..t+L.
  - TIMED: cnt decrements each cycle; at cnt=1 it returns to IDLE on the next edge.
  - timed_req in TIMED is ignored; timed_req with L=0 is ignored.
  - A request on the edge the FSM returns to IDLE is also ignored; it is accepted only when the FSM is IDLE.
  - The counter decrements regardless of other stalls.
- Exception (exc_req=1 at edge t) has highest priority. At t+1:
  - redirect_valid=1, redirect_pc=exc_pc, flush[EXC_STAGE:0]=1 for exactly one cycle.
  - FSM goes to IDLE with cnt=0; a same-cycle timed_req is discarded.
- Branch (br_req=1 at edge t, exc_req=0): accepted only if stall[BR_STAGE]=0 in that cycle; otherwise ignored, and the requester holds br_req.
  - If accepted, at t+1: redirect_valid=1, redirect_pc=br_pc, flush[BR_STAGE-1:0]=1 for one cycle.
  - The timed FSM is unaffected.
- Simultaneous br_req and exc_req: exception wins; branch is dropped.
- Back-to-back requests give back-to-back one-cycle pulses. Outputs hold 0 in cycles with no accepted request.
- Watchdog:
  - Counter increments each cycle stall[0]=1 and clears to 0 on any cycle stall[0]=0.
  - On reaching 2^WDOG_WIDTH-1 (saturating), wdog_err is set on the next edge.
  - wdog_err is sticky until RST.
- Reset mid-operation: RST on any edge cancels pending pulses, TIMED state and wdog_err; outputs return to reset values the next cycle.

Decomposition:
- Package pipe_ctrl_pkg:
  - stage index constants (STG_IF=0, STG_ID=1, STG_EX=3, STG_MEM=4, STG_WB=5);
  - FSM state enum {IDLE, TIMED};
  - default PC_WIDTH and CNT_WIDTH.
- Sub-module stall_mask_gen: parametrised combinational prefix mask. Input is the eff vector; output is ones from bit 0 up to the highest set bit, implemented as a suffix-OR.
- Timed FSM, redirect register and watchdog stay in the top module.

Test Plan:
- Prefix mask, N=6: stallreq=000100 gives stall=000111; stallreq=010010 gives 011111; stallreq=0 gives 000000. RST=1 with stallreq=111111 gives stall=0.
- Timed stall: timed_req, timed_len=3 at edge 10 → timed_busy=1 and stall=001111 during cycles 11-13, 0 at 14. timed_req at edge 12 is ignored; len=0 never sets busy.
- Branch: br_req, br_pc=0x80 at edge 5, no stalls → cycle 6 redirect_valid=1, redirect_pc=0x80, flush=000111, then 0. Same stimulus with stallreq=010000 → no redirect.
- Exception priority: exc_req, exc_pc=0x100 and br_req, br_pc=0x80 together at edge 20, during TIMED → cycle 21 redirect_pc=0x100, flush=011111, timed_busy=0.
- Watchdog, WDOG_WIDTH=4: hold stallreq[1]=1 for 15 cycles → wdog_err=1 and stays 1 after release. A 14-cycle hold then a 1-cycle release leaves wdog_err=0. RST clears it.
- Mid-op reset: RST during TIMED with cnt=5 → timed_busy=0 and flush=0 next cycle; timed_req accepted immediately after RST deasserts.
